// File: rtl/wb_regfile_pkg.sv
// Shared widths, constants and helpers for the register file and scoreboard.
// Optional REGFILE_BYPASS_EN forwards the retiring write to the read ports.
package wb_regfile_pkg;
   localparam int RegBus     = 32;
   localparam int RegAddrBus = 5;
   localparam int RegNum     = 32;
   localparam int CntW       = 2;

   localparam logic [RegAddrBus-1:0] NOPRegAddr   = '0;
   localparam logic [RegBus-1:0]     ZeroWord     = '0;
   localparam logic                  WriteEnable  = 1'b1;
   localparam logic                  WriteDisable = 1'b0;
   localparam logic [CntW-1:0]       CntMax       = '1;

   typedef logic [RegBus-1:0]     reg_t;
   typedef logic [RegAddrBus-1:0] addr_t;
   typedef logic [CntW-1:0]       cnt_t;

   // A write only counts when it targets a real register; r0 is hardwired.
   function automatic logic is_wr(input logic en, input addr_t a);
      return (en == WriteEnable) && (a != NOPRegAddr);
   endfunction

   function automatic reg_t rd_mux(input logic re, input addr_t a, input reg_t arr_val,
                                   input logic hit, input reg_t wdata);
      if (!re || a == NOPRegAddr) return ZeroWord;
      if (hit) return wdata;
      return arr_val;
   endfunction
endpackage

// File: rtl/wb_scoreboard.sv
// Per-register in-flight write counters, sticky over/underflow flag and the
// decode stall request derived from them.
module wb_scoreboard
   import wb_regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_iss_valid,
   input  logic                  i_iss_wreg,
   input  logic [RegAddrBus-1:0] i_iss_wd,
   input  logic                  i_wb_wreg,
   input  logic [RegAddrBus-1:0] i_wb_wd,
   input  logic                  i_flush,
   input  logic                  i_re1,
   input  logic [RegAddrBus-1:0] i_raddr1,
   input  logic                  i_re2,
   input  logic [RegAddrBus-1:0] i_raddr2,
   output logic                  o_stallreq,
   output logic                  o_sb_err
);
   cnt_t              r_cnt [RegNum];
   logic              r_sb_err;
   logic              w_inc;
   logic              w_dec;
   logic [RegNum-1:0] w_inc_vec;
   logic [RegNum-1:0] w_dec_vec;
   logic              w_pend1;
   logic              w_pend2;

   assign w_inc     = i_iss_valid && is_wr(i_iss_wreg, i_iss_wd);
   assign w_dec     = is_wr(i_wb_wreg, i_wb_wd);
   assign w_inc_vec = w_inc ? (RegNum'(1) << i_iss_wd) : '0;
   assign w_dec_vec = w_dec ? (RegNum'(1) << i_wb_wd) : '0;

   always_ff @(posedge clk) begin
      if (rst || i_flush) begin
         for (int i = 0; i < RegNum; i++) r_cnt[i] <= '0;
         if (rst) r_sb_err <= 1'b0;
      end else begin
         // Saturate rather than wrap so a broken pipeline never unblocks a hazard.
         for (int i = 1; i < RegNum; i++) begin
            if (w_inc_vec[i] && !w_dec_vec[i]) begin
               if (r_cnt[i] == CntMax) r_sb_err <= 1'b1;
               else                    r_cnt[i] <= r_cnt[i] + 1'b1;
            end else if (w_dec_vec[i] && !w_inc_vec[i]) begin
               if (r_cnt[i] == '0) r_sb_err <= 1'b1;
               else                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
         end
      end
   end

`ifdef REGFILE_BYPASS_EN
   // The write retiring this cycle is forwarded, so it no longer blocks.
   logic w_ret1;
   logic w_ret2;
   assign w_ret1  = w_dec && (i_wb_wd == i_raddr1);
   assign w_ret2  = w_dec && (i_wb_wd == i_raddr2);
   assign w_pend1 = r_cnt[i_raddr1] > cnt_t'(w_ret1);
   assign w_pend2 = r_cnt[i_raddr2] > cnt_t'(w_ret2);
`else
   assign w_pend1 = r_cnt[i_raddr1] != '0;
   assign w_pend2 = r_cnt[i_raddr2] != '0;
`endif

   assign o_stallreq = (i_re1 && i_raddr1 != NOPRegAddr && w_pend1) ||
                       (i_re2 && i_raddr2 != NOPRegAddr && w_pend2);
   assign o_sb_err   = r_sb_err;
endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file with two combinational read ports and write-back
// scoreboard. Define REGFILE_BYPASS_EN to forward write-back data to reads.
module wb_regfile
   import wb_regfile_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_wb_wreg,
   input  logic [RegAddrBus-1:0] i_wb_wd,
   input  logic [RegBus-1:0]     i_wb_wdata,
   input  logic                  i_re1,
   input  logic                  i_re2,
   input  logic [RegAddrBus-1:0] i_raddr1,
   input  logic [RegAddrBus-1:0] i_raddr2,
   output logic [RegBus-1:0]     o_rdata1,
   output logic [RegBus-1:0]     o_rdata2,
   input  logic                  i_iss_valid,
   input  logic                  i_iss_wreg,
   input  logic [RegAddrBus-1:0] i_iss_wd,
   input  logic                  i_flush,
   output logic                  o_stallreq,
   output logic                  o_sb_err
);
   reg_t r_regs [RegNum];
   logic w_wr;
   logic w_hit1;
   logic w_hit2;

   assign w_wr = is_wr(i_wb_wreg, i_wb_wd);

   // Array writes are independent of scoreboard state, including during flush.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < RegNum; i++) r_regs[i] <= ZeroWord;
      end else if (w_wr) begin
         r_regs[i_wb_wd] <= i_wb_wdata;
      end
   end

`ifdef REGFILE_BYPASS_EN
   assign w_hit1 = w_wr && (i_wb_wd == i_raddr1);
   assign w_hit2 = w_wr && (i_wb_wd == i_raddr2);
`else
   assign w_hit1 = 1'b0;
   assign w_hit2 = 1'b0;
`endif

   assign o_rdata1 = rd_mux(i_re1, i_raddr1, r_regs[i_raddr1], w_hit1, i_wb_wdata);
   assign o_rdata2 = rd_mux(i_re2, i_raddr2, r_regs[i_raddr2], w_hit2, i_wb_wdata);

   wb_scoreboard u_sb (
      .clk         (clk),
      .rst         (rst),
      .i_iss_valid (i_iss_valid),
      .i_iss_wreg  (i_iss_wreg),
      .i_iss_wd    (i_iss_wd),
      .i_wb_wreg   (i_wb_wreg),
      .i_wb_wd     (i_wb_wd),
      .i_flush     (i_flush),
      .i_re1       (i_re1),
      .i_raddr1    (i_raddr1),
      .i_re2       (i_re2),
      .i_raddr2    (i_raddr2),
      .o_stallreq  (o_stallreq),
      .o_sb_err    (o_sb_err)
   );
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table for the corner cases, then
// randomized traffic checked against an integer-count reference model.
module tb_wb_regfile;
`ifdef REGFILE_BYPASS_EN
   localparam bit BP = 1'b1;
`else
   localparam bit BP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        i_wb_wreg;
   logic [4:0]  i_wb_wd;
   logic [31:0] i_wb_wdata;
   logic        i_re1, i_re2;
   logic [4:0]  i_raddr1, i_raddr2;
   logic [31:0] o_rdata1, o_rdata2;
   logic        i_iss_valid, i_iss_wreg;
   logic [4:0]  i_iss_wd;
   logic        i_flush;
   logic        o_stallreq, o_sb_err;

   always #5 clk = ~clk;

   wb_regfile dut (
      .clk(clk), .rst(rst),
      .i_wb_wreg(i_wb_wreg), .i_wb_wd(i_wb_wd), .i_wb_wdata(i_wb_wdata),
      .i_re1(i_re1), .i_re2(i_re2), .i_raddr1(i_raddr1), .i_raddr2(i_raddr2),
      .o_rdata1(o_rdata1), .o_rdata2(o_rdata2),
      .i_iss_valid(i_iss_valid), .i_iss_wreg(i_iss_wreg), .i_iss_wd(i_iss_wd),
      .i_flush(i_flush), .o_stallreq(o_stallreq), .o_sb_err(o_sb_err)
   );

   typedef struct packed {
      logic        rs;
      logic        ww;
      logic [4:0]  wd;
      logic [31:0] wdat;
      logic        re;
      logic [4:0]  ra;
      logic        iss;
      logic [4:0]  iwd;
      logic        fl;
      logic [31:0] erd;
      logic        est;
      logic        eerr;
   } vec_t;

   vec_t tv[$];
   int checks = 0;
   int errors = 0;
   int cur    = 0;

   // Reference state: plain values and in-flight counts.
   logic [31:0] m_regs [32];
   int          m_cnt  [32];
   bit          m_err;

   function automatic vec_t mk(bit rs, bit ww, int wd, logic [31:0] wdat, bit re, int ra,
                               bit iss, int iwd, bit fl, logic [31:0] erd, bit est, bit eerr);
      vec_t v;
      v.rs = rs; v.ww = ww; v.wd = 5'(wd); v.wdat = wdat; v.re = re; v.ra = 5'(ra);
      v.iss = iss; v.iwd = 5'(iwd); v.fl = fl; v.erd = erd; v.est = est; v.eerr = eerr;
      return v;
   endfunction

   function automatic bit wb_act();
      return i_wb_wreg && i_wb_wd != 0;
   endfunction

   function automatic logic [31:0] m_rdata(logic re, logic [4:0] a);
      if (!re || a == 0) return 32'h0;
      if (BP && wb_act() && i_wb_wd == a) return i_wb_wdata;
      return m_regs[a];
   endfunction

   function automatic bit m_pend(logic re, logic [4:0] a);
      int eff;
      if (!re || a == 0) return 1'b0;
      eff = m_cnt[a] - ((BP && wb_act() && i_wb_wd == a) ? 1 : 0);
      return eff > 0;
   endfunction

   task automatic m_step();
      bit inc, dec;
      if (rst) begin
         for (int i = 0; i < 32; i++) begin m_regs[i] = 0; m_cnt[i] = 0; end
         m_err = 0;
         return;
      end
      dec = wb_act();
      if (dec) m_regs[i_wb_wd] = i_wb_wdata;
      if (i_flush) begin
         for (int i = 0; i < 32; i++) m_cnt[i] = 0;
         return;
      end
      inc = i_iss_valid && i_iss_wreg && i_iss_wd != 0;
      if (inc && dec && i_iss_wd == i_wb_wd) return;
      if (inc) begin
         if (m_cnt[i_iss_wd] == 3) m_err = 1; else m_cnt[i_iss_wd]++;
      end
      if (dec) begin
         if (m_cnt[i_wb_wd] == 0) m_err = 1; else m_cnt[i_wb_wd]--;
      end
   endtask

   task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s step %0d got %h exp %h", nm, cur, got, exp);
      end
   endtask

   // Inputs are already driven; compare mid-cycle, then advance model and DUT.
   task automatic run_cycle(bit use_tab, vec_t v);
      @(negedge clk);
      chk("model_rdata1", o_rdata1, m_rdata(i_re1, i_raddr1));
      chk("model_rdata2", o_rdata2, m_rdata(i_re2, i_raddr2));
      chk("model_stall", 32'(o_stallreq), 32'(m_pend(i_re1, i_raddr1) || m_pend(i_re2, i_raddr2)));
      chk("model_sb_err", 32'(o_sb_err), 32'(m_err));
      if (use_tab) begin
         chk("tab_rdata1", o_rdata1, v.erd);
         chk("tab_stall", 32'(o_stallreq), 32'(v.est));
         chk("tab_sb_err", 32'(o_sb_err), 32'(v.eerr));
      end
      @(posedge clk);
      m_step();
      #1;
      cur++;
   endtask

   initial begin
      vec_t v;
      tv.push_back(mk(0,1,0,32'hFFFFFFFF,1,0,0,0,0, 32'h0,0,0));
      tv.push_back(mk(0,0,0,0,1,0,0,0,0, 32'h0,0,0));
      tv.push_back(mk(0,0,0,0,1,5,1,5,0, 32'h0,0,0));
      tv.push_back(mk(0,1,5,32'h12345678,1,5,0,0,0, BP ? 32'h12345678 : 32'h0, !BP,0));
      tv.push_back(mk(0,0,0,0,1,5,0,0,0, 32'h12345678,0,0));
      tv.push_back(mk(0,0,0,0,1,7,1,7,0, 32'h0,0,0));
      tv.push_back(mk(0,0,0,0,1,7,0,0,0, 32'h0,1,0));
      tv.push_back(mk(0,0,0,0,1,7,0,0,0, 32'h0,1,0));
      tv.push_back(mk(0,1,7,32'hA5,1,7,0,0,0, BP ? 32'hA5 : 32'h0, !BP,0));
      tv.push_back(mk(0,0,0,0,1,7,0,0,0, 32'hA5,0,0));
      tv.push_back(mk(0,0,0,0,1,12,1,12,0, 32'h0,0,0));
      tv.push_back(mk(0,1,12,32'h12,1,12,1,12,0, BP ? 32'h12 : 32'h0, !BP,0));
      tv.push_back(mk(0,0,0,0,1,12,0,0,0, 32'h12,1,0));
      tv.push_back(mk(0,0,0,0,1,4,1,4,0, 32'h0,0,0));
      tv.push_back(mk(0,0,0,0,1,4,1,4,0, 32'h0,1,0));
      tv.push_back(mk(0,1,4,32'h55,1,4,1,4,1, BP ? 32'h55 : 32'h0, 1,0));
      tv.push_back(mk(0,0,0,0,1,4,0,0,0, 32'h55,0,0));
      tv.push_back(mk(0,0,0,0,1,12,0,0,0, 32'h12,0,0));
      for (int k = 0; k < 4; k++) tv.push_back(mk(0,0,0,0,0,0,1,9,0, 32'h0,0,0));
      tv.push_back(mk(0,0,0,0,1,9,0,0,0, 32'h0,1,1));
      tv.push_back(mk(0,1,3,32'h33,1,9,0,0,0, 32'h0,1,1));
      tv.push_back(mk(0,0,0,0,1,3,0,0,0, 32'h33,0,1));
      tv.push_back(mk(0,1,9,32'h1,1,9,0,0,0, BP ? 32'h1 : 32'h0, 1,1));
      tv.push_back(mk(0,1,9,32'h2,1,9,0,0,0, BP ? 32'h2 : 32'h1, 1,1));
      tv.push_back(mk(0,1,9,32'h3,1,9,0,0,0, BP ? 32'h3 : 32'h2, !BP,1));
      tv.push_back(mk(0,0,0,0,1,9,0,0,0, 32'h3,0,1));
      tv.push_back(mk(0,0,0,0,1,12,1,12,0, 32'h12,0,1));
      tv.push_back(mk(1,1,7,32'hDEAD,1,12,1,6,0, 32'h12,1,1));
      tv.push_back(mk(0,0,0,0,1,12,0,0,0, 32'h0,0,0));
      tv.push_back(mk(0,0,0,0,1,7,0,0,0, 32'h0,0,0));
      tv.push_back(mk(0,0,0,0,1,6,0,0,0, 32'h0,0,0));

      rst = 1; i_wb_wreg = 0; i_wb_wd = 0; i_wb_wdata = 0;
      i_re1 = 0; i_re2 = 0; i_raddr1 = 0; i_raddr2 = 0;
      i_iss_valid = 0; i_iss_wreg = 0; i_iss_wd = 0; i_flush = 0;
      repeat (2) @(posedge clk);
      m_step();
      #1;
      rst = 0;

      foreach (tv[k]) begin
         v = tv[k];
         rst = v.rs; i_wb_wreg = v.ww; i_wb_wd = v.wd; i_wb_wdata = v.wdat;
         i_re1 = v.re; i_raddr1 = v.ra;
         i_iss_valid = v.iss; i_iss_wreg = v.iss; i_iss_wd = v.iwd; i_flush = v.fl;
         i_re2 = 1'(($urandom_range(0, 1)));
         i_raddr2 = 5'($urandom_range(0, 31));
         run_cycle(1'b1, v);
      end

      // Narrow address range so hazards, collisions and saturation are frequent.
      v = '0;
      for (int n = 0; n < 600; n++) begin
         rst         = ($urandom_range(0, 63) == 0);
         i_flush     = ($urandom_range(0, 15) == 0);
         i_wb_wreg   = 1'($urandom_range(0, 1));
         i_wb_wd     = 5'($urandom_range(0, 7));
         i_wb_wdata  = $urandom;
         i_iss_valid = ($urandom_range(0, 3) != 0);
         i_iss_wreg  = ($urandom_range(0, 3) != 0);
         i_iss_wd    = 5'($urandom_range(0, 7));
         i_re1       = 1'($urandom_range(0, 1));
         i_re2       = 1'($urandom_range(0, 1));
         i_raddr1    = 5'($urandom_range(0, 7));
         i_raddr2    = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
         run_cycle(1'b0, v);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
